// File: rtl/mmio_pkg.sv
// Register map, TCON bit positions and default window base shared by the MMIO timer/LED block.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LEDS    = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/mmio_timer.sv
// Reloadable 32-bit timer (TH/TL/TCON) with overflow interrupt; register updates one edge after a write.
// No backpressure: CPU writes are always accepted and win over counting, except the sticky overflow flag.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th_i,
  input  logic        we_tl_i,
  input  logic        we_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d   = we_th_i ? wdata_i : th_q;

    tl_d = tl_q;
    if (we_tl_i)
      tl_d = wdata_i;
    else if (tcon_q[TCON_EN])
      tl_d = ovf ? th_q : tl_q + 32'd1;

    tcon_d = we_tcon_i ? wdata_i[2:0] : tcon_q;
    // Overflow must not be lost to a simultaneous software clear.
    if (ovf && tcon_q[TCON_IE])
      tcon_d[TCON_IS] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/mmio_timer_leds.sv
// MMIO window: timer, SysTick, LED and seven-segment registers; zero-latency combinational decode/read.
// No backpressure: every access in the window completes in the cycle it is presented.
module mmio_timer_leds
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        hit,
  output logic [31:0] Read_data,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq
);

  logic [2:0]  off;
  logic        wr;
  logic        unused_addr_lsbs;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  leds_q;
  logic [11:0] digi_q;
  logic [31:0] systick_q;
  logic [31:0] rdata;

  assign hit              = (Address[31:5] == BASE_ADDR[31:5]);
  assign off              = Address[4:2];
  assign wr               = MemWrite & hit;
  assign unused_addr_lsbs = ^Address[1:0];

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .we_th_i   (wr && off == OFF_TH),
    .we_tl_i   (wr && off == OFF_TL),
    .we_tcon_i (wr && off == OFF_TCON),
    .wdata_i   (Write_data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 32'd1;
      if (wr && off == OFF_LEDS) leds_q <= Write_data[7:0];
      if (wr && off == OFF_DIGI) digi_q <= Write_data[11:0];
    end
  end

  // Reads see the pre-edge register values, so read+write returns the old value.
  always_comb begin
    rdata = '0;
    if (MemRead && hit) begin
      case (off)
        OFF_TH:      rdata = th;
        OFF_TL:      rdata = tl;
        OFF_TCON:    rdata = {29'b0, tcon};
        OFF_LEDS:    rdata = {24'b0, leds_q};
        OFF_DIGI:    rdata = {20'b0, digi_q};
        OFF_SYSTICK: rdata = systick_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign Read_data = rdata;
  assign leds      = leds_q;
  assign digi      = digi_q;

endmodule

// File: tb/tb_mmio_timer_leds.sv
// Directed bench for mmio_timer_leds: expected values queued with each stimulus step, popped when sampled.
module tb_mmio_timer_leds;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = BASE;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        hit;
  logic [31:0] Read_data;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer_leds #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .hit        (hit),
    .Read_data  (Read_data),
    .leds       (leds),
    .digi       (digi),
    .irq        (irq)
  );

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] addr_of(input logic [2:0] off);
    return BASE + {27'b0, off, 2'b00};
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required <none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push_exp(tag, e);
    compare(obs);
  endtask

  task automatic read_check_addr(input string tag, input logic [31:0] a, input logic [31:0] e);
    push_exp(tag, e);
    Address = a;
    MemRead = 1'b1;
    #1;
    compare(Read_data);
    MemRead = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] off, input logic [31:0] e);
    read_check_addr(tag, addr_of(off), e);
  endtask

  task automatic read_val(input logic [2:0] off, output logic [31:0] v);
    Address = addr_of(off);
    MemRead = 1'b1;
    #1;
    v = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    wr_addr(addr_of(off), d);
  endtask

  logic [31:0] s1, s2;

  initial begin
    // Reset state
    MemRead = 1'b1;
    #2;
    push_exp("reset_th_read", 32'h0);
    compare(Read_data);
    check("reset_hit", {31'b0, hit}, 32'd1);
    check("reset_leds", {24'b0, leds}, 32'h0);
    check("reset_digi", {20'b0, digi}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count
    wr(OFF_LEDS, 32'h5A);
    wr(OFF_TCON, 32'h3);
    repeat (10) @(negedge clk);
    read_check("tl_after_10", OFF_TL, 32'd10);
    #1 reset = 1'b1;
    read_check("rst_tl", OFF_TL, 32'h0);
    read_check("rst_tcon", OFF_TCON, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_leds", {24'b0, leds}, 32'h0);
    reset = 1'b0;

    // Overflow and reload
    wr(OFF_TH, 32'hFFFF_FFFC);
    wr(OFF_TL, 32'hFFFF_FFFE);
    wr(OFF_TCON, 32'h3);
    read_check("ovf_tl0", OFF_TL, 32'hFFFF_FFFE);
    @(negedge clk);
    read_check("ovf_tl1", OFF_TL, 32'hFFFF_FFFF);
    check("ovf_irq_before", {31'b0, irq}, 32'h0);
    @(negedge clk);
    read_check("ovf_reload", OFF_TL, 32'hFFFF_FFFC);
    check("ovf_irq_after", {31'b0, irq}, 32'h1);
    read_check("ovf_tcon", OFF_TCON, 32'h7);

    // Simultaneous software clear and overflow
    wr(OFF_TCON, 32'h0);
    wr(OFF_TL, 32'hFFFF_FFFE);
    wr(OFF_TCON, 32'h3);
    read_check("clr_tl_pre", OFF_TL, 32'hFFFF_FFFE);
    read_check("clr_tcon_pre", OFF_TCON, 32'h3);
    wr(OFF_TCON, 32'h3);
    read_check("clr_tcon_ovf", OFF_TCON, 32'h7);
    check("clr_irq_ovf", {31'b0, irq}, 32'h1);
    read_check("clr_tl_reload", OFF_TL, 32'hFFFF_FFFC);
    wr(OFF_TCON, 32'h2);
    check("sw_clear_irq", {31'b0, irq}, 32'h0);
    read_check("sw_clear_tcon", OFF_TCON, 32'h2);

    // Peripheral registers
    wr(OFF_LEDS, 32'h0000_00A5);
    wr(OFF_DIGI, 32'hFFFF_F3C0);
    check("leds_out", {24'b0, leds}, 32'hA5);
    check("digi_out", {20'b0, digi}, 32'h3C0);
    read_check("leds_read", OFF_LEDS, 32'hA5);
    read_check("digi_read", OFF_DIGI, 32'h3C0);

    // Decode boundaries
    read_check_addr("reserved_read", BASE + 32'h18, 32'h0);
    check("reserved_hit", {31'b0, hit}, 32'h1);
    read_check_addr("outside_read", BASE + 32'h20, 32'h0);
    check("outside_hit", {31'b0, hit}, 32'h0);
    wr_addr(BASE + 32'h2C, 32'hFF);
    check("outside_write_ignored", {24'b0, leds}, 32'hA5);
    Address = addr_of(OFF_LEDS);
    MemRead = 1'b0;
    #1;
    check("no_memread_zero", Read_data, 32'h0);

    // Read and write together return the old value
    @(negedge clk);
    Address    = addr_of(OFF_LEDS);
    Write_data = 32'h3C;
    MemWrite   = 1'b1;
    MemRead    = 1'b1;
    #1;
    check("rw_old_value", Read_data, 32'hA5);
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    read_check("rw_new_value", OFF_LEDS, 32'h3C);

    // SysTick is read-only and free-running
    wr(OFF_SYSTICK, 32'h0);
    read_val(OFF_SYSTICK, s1);
    repeat (5) @(negedge clk);
    read_val(OFF_SYSTICK, s2);
    check("systick_delta", s2 - s1, 32'd5);
    check("systick_write_ignored", {31'b0, (s1 > 32'd20)}, 32'h1);

    // TL write wins over counting
    wr(OFF_TCON, 32'h1);
    wr(OFF_TL, 32'h1234);
    read_check("tl_write_wins", OFF_TL, 32'h1234);
    @(negedge clk);
    read_check("tl_counts_on", OFF_TL, 32'h1235);

    if (exp_q.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
